// File: rtl/password_enroll.sv
// Purpose: enrol a 4-digit switch code by entering it twice; on a match, write it out with a strobe.
// Latency: a digit is accepted on the STABLE_CYCLES-th identical sample; the display and LEDs update one cycle later.
// Backpressure: none. The result is held for HOLD_CYCLES and Sw is ignored during that time.
module password_enroll #(
  parameter int STABLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  Sw,
  output logic [9:0]  leds_out,
  output logic [7:0]  seg0_out,
  output logic [7:0]  seg1_out,
  output logic [7:0]  seg2_out,
  output logic [7:0]  seg3_out,
  output logic [7:0]  seg4_out,
  output logic [15:0] pass_out,
  output logic        pass_wr
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {ENTER1, ENTER2, MATCH, MISMATCH} state_t;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0: seg_enc = 8'hC0;
      4'd1: seg_enc = 8'hF9;
      4'd2: seg_enc = 8'hA4;
      4'd3: seg_enc = 8'hB0;
      4'd4: seg_enc = 8'h99;
      4'd5: seg_enc = 8'h92;
      4'd6: seg_enc = 8'h82;
      4'd7: seg_enc = 8'hF8;
      4'd8: seg_enc = 8'h80;
      4'd9: seg_enc = 8'h90;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic [9:0]      sw_q;
  logic [RW-1:0]   run_cnt, run_nxt;
  logic            acc_done;
  logic            same, ep_done, entering, accept, last_digit, codes_eq, leaving;
  logic [3:0]      digit;
  logic [1:0]      cnt;
  logic [15:0]     code_q, code_a, code_full;
  logic [HW-1:0]   hold_cnt;
  logic [7:0]      seg_q [4];

  // Episode tracking: run length of the current identical-sample run, and whether it already produced a digit.
  always_comb begin
    same     = (run_cnt != '0) && (Sw == sw_q);
    run_nxt  = RW'(1);
    if (same) run_nxt = (run_cnt == RW'(STABLE_CYCLES)) ? run_cnt : run_cnt + 1'b1;
    ep_done  = same && acc_done;
    entering = (state == ENTER1) || (state == ENTER2);
    accept   = entering && $onehot(Sw) && (run_nxt == RW'(STABLE_CYCLES)) && !ep_done;
    digit    = 4'd0;
    for (int i = 0; i < 10; i++) if (Sw[i]) digit = 4'(i);
    last_digit = accept && (cnt == 2'd3);
    code_full  = {code_q[11:0], digit};
    codes_eq   = (code_full == code_a);
    leaving    = (hold_cnt == HW'(HOLD_CYCLES - 1));
  end

  // Sampler registers; result states mark every episode consumed so held switches need a change after return.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q     <= '0;
      run_cnt  <= '0;
      acc_done <= 1'b0;
    end else begin
      sw_q     <= Sw;
      run_cnt  <= run_nxt;
      acc_done <= entering ? (ep_done || accept) : 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ENTER1:   if (last_digit) state_nxt = ENTER2;
      ENTER2:   if (last_digit) state_nxt = codes_eq ? MATCH : MISMATCH;
      MATCH,
      MISMATCH: if (leaving) state_nxt = ENTER1;
      default:  state_nxt = ENTER1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ENTER1;
    else     state <= state_nxt;
  end

  // Digit collection, display shift register, result hold timer and enrolled-code output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      code_q   <= '0;
      code_a   <= '0;
      hold_cnt <= '0;
      pass_out <= '0;
      pass_wr  <= 1'b0;
      for (int i = 0; i < 4; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      pass_wr <= 1'b0;
      if (accept) begin
        cnt      <= cnt + 2'd1;
        code_q   <= code_full;
        seg_q[0] <= seg_enc(digit);
        for (int i = 1; i < 4; i++) seg_q[i] <= seg_q[i-1];
      end
      if (last_digit) begin
        cnt      <= 2'd0;
        code_q   <= '0;
        hold_cnt <= '0;
        for (int i = 0; i < 4; i++) seg_q[i] <= SEG_BLANK;
        if (state == ENTER1) begin
          code_a <= code_full;
        end else if (codes_eq) begin
          pass_out <= code_a;
          pass_wr  <= 1'b1;
          for (int i = 0; i < 4; i++) seg_q[i] <= seg_enc(code_a[4*i +: 4]);
        end
      end
      if (!entering) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (leaving) begin
          hold_cnt <= '0;
          for (int i = 0; i < 4; i++) seg_q[i] <= SEG_BLANK;
        end
      end
    end
  end

  // Phase indicator and status LEDs follow the registered state and digit count.
  always_comb begin
    leds_out = '0;
    case (cnt)
      2'd1:    leds_out[3:0] = 4'b0001;
      2'd2:    leds_out[3:0] = 4'b0011;
      2'd3:    leds_out[3:0] = 4'b0111;
      default: leds_out[3:0] = 4'b0000;
    endcase
    leds_out[4] = (state == ENTER2);
    leds_out[8] = (state == MISMATCH);
    leds_out[9] = (state == MATCH);
    case (state)
      ENTER1:   seg4_out = 8'hF9;
      ENTER2:   seg4_out = 8'hA4;
      MATCH:    seg4_out = 8'h8C;
      default:  seg4_out = 8'h86;
    endcase
    seg0_out = seg_q[0];
    seg1_out = seg_q[1];
    seg2_out = seg_q[2];
    seg3_out = seg_q[3];
  end

endmodule

// File: doc/password_enroll.md
Name: password_enroll

Overview:
- Enrollment block for the switch/7-segment password lock. It captures a new 4-digit code from one-hot switches Sw[9:0], then requires the same code a second time to confirm it.
- On a match it writes the code to the checker with a one-cycle pass_wr strobe. On a mismatch it shows an error and restarts.
- Drives the same board LEDs and five 7-segment displays that the checker drives, and is muxed with it at board top.

Parameters:
STABLE_CYCLES, 2, consecutive identical valid samples required to accept a digit (>=1)
HOLD_CYCLES, 4, cycles the MATCH/MISMATCH result is displayed before returning to entry (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
Sw  input  10  digit switches; one-hot Sw[i] means digit i
leds_out  output  10  status LEDs
seg0_out  output  8  rightmost digit, active-low {dp,g,f,e,d,c,b,a}
seg1_out  output  8  digit display 1
seg2_out  output  8  digit display 2
seg3_out  output  8  leftmost code digit
seg4_out  output  8  phase/result indicator
pass_out  output  16  enrolled code, 4 BCD nibbles, first digit in [15:12]
pass_wr  output  1  one-cycle strobe, pass_out newly valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - leds_out=0, seg0..3_out=8'hFF (blank), seg4_out=8'hF9 ('1').
  - pass_out=16'h0000, pass_wr=0, state ENTER1, digit count 0.
  - Stability counter and accept flag are cleared.
- Reset mid-operation: rst has priority over all logic at any cycle.
- Digit detection:
  - Sw is sampled every edge.
  - An "episode" is a run of consecutive identical samples. It ends when a sample differs from the previous sample.
  - A digit is accepted at the edge where the same valid one-hot value has been sampled on STABLE_CYCLES consecutive edges. It is accepted at most once per episode.
  - Zero samples and multi-bit samples never accept.
  - A switch held long produces exactly one digit. A repeated digit needs an intervening different sample (e.g. 0).
  - Sw held through reset must be re-qualified after reset is released.
  - Digit value is the index of the set bit, 0..9.
- Segment codes (active-low, dp off):
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Letters: P=8C, E=86. Blank=FF.
- Display of accepted digits: digits shift in from the right. Each accepted digit goes to seg0; earlier digits move seg0->seg1->seg2->seg3. Visible the cycle after the accepting edge.
- States:
  - ENTER1: collect 4 digits into code A. seg4='1'. On the 4th digit, go to ENTER2, blank seg0..3, count=0, seg4='2'.
  - ENTER2: collect 4 digits into code B. On the 4th digit, compare B with A:
    - equal -> MATCH: same edge load pass_out=A, pass_wr=1 for exactly that one cycle.
    - unequal -> MISMATCH.
  - MATCH: seg3..0 show A, seg4='P', leds_out[9]=1. Digit acceptance is suppressed.
  - MISMATCH: seg0..3 blank, seg4='E', leds_out[8]=1. pass_out is unchanged and pass_wr stays 0. Acceptance is suppressed.
  - Leaving MATCH/MISMATCH: after HOLD_CYCLES cycles in either state, go to ENTER1 with count 0, seg0..3 blank, seg4='1'.
  - Episodes that began during MATCH/MISMATCH do not accept after return until Sw changes.
- LEDs:
  - leds_out[3:0] = thermometer of the digit count in the current phase (1 digit=0001, 3 digits=0111). Cleared on phase change.
  - leds_out[4] = 1 in ENTER2.
  - leds_out[9:8] as described under MATCH/MISMATCH.
  - leds_out[7:5] = 0.
- pass_out holds its last enrolled value until the next MATCH or rst.

Test Plan:
- Reset: rst=1 for 2 cycles with Sw=0 -> leds_out=0, seg0..3=FF, seg4=F9, pass_out=0, pass_wr=0.
- Enroll success (defaults): Sw=1,2,4,8 each held 2 cycles -> seg4=A4, leds_out=10'h010. Repeat the same sequence -> single-cycle pass_wr, pass_out=16'h0123, seg3..0=C0,F9,A4,B0, seg4=8C, leds_out[9]=1. 4 cycles later seg4=F9 and leds_out=0.
- Mismatch: enter 0,1,2,3 then 0,1,2,4 -> seg4=86 and leds_out[8]=1 for 4 cycles, pass_wr never asserted, pass_out keeps its prior value, then back to ENTER1.
- Qualification:
  - Sw=10'b0000000011 held 10 cycles -> no digit.
  - Sw=1 held 1 cycle, then Sw=0 -> no digit.
  - Sw=1 held 20 cycles -> exactly one digit, leds_out[3:0]=0001.
  - Sw=1 (2 cycles), 0 (2 cycles), 1 (2 cycles) -> two '0' digits, seg1=seg0=C0.
- Reset mid-entry: in ENTER2 after 3 digits, rst=1 for 1 cycle while Sw=8 held -> all reset values, and no digit accepted until Sw is sampled stable again for 2 cycles after reset release.
